// File: rtl/reset_sequencer.sv
// Staged reset generator for the pclk domain: merges rst, PLL lock and pushbutton, holds, then releases outputs in order.
// Optional macro BTN_DEBOUNCE_EN adds a registered debounce filter on the pushbutton request.
module reset_sequencer #(
    parameter int NUM_OUT         = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_GAP       = 8,
    parameter int CNT_W           = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               btn_rst,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               rst_done,
    output logic [1:0]         seq_state
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam bit MULTI = (NUM_OUT > 1);
    localparam logic [NUM_OUT-1:0] ALL_ONES  = {NUM_OUT{1'b1}};
    localparam logic [NUM_OUT-1:0] ONE       = NUM_OUT'(1'b1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_OUT - 1);

    if (NUM_OUT < 1 || NUM_OUT > 8 || SYNC_STAGES < 2 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
        DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_params
        $error("reset_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] locked_sync_r;
    logic [SYNC_STAGES-1:0] btn_sync_r;
    logic                   locked_s;
    logic                   btn_s;
    logic                   btn_req;
    logic                   src_ok;

    state_t             state_r, state_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic [IDX_W-1:0]   stage_r, stage_n;
    logic [NUM_OUT-1:0] rst_out_r, rst_out_n;
    logic               rst_done_r, rst_done_n;

    // Two-flop (or deeper) synchronisers for the asynchronous lock and button inputs
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            locked_sync_r <= '0;
            btn_sync_r    <= '0;
        end else begin
            locked_sync_r <= {locked_sync_r[SYNC_STAGES-2:0], locked};
            btn_sync_r    <= {btn_sync_r[SYNC_STAGES-2:0], btn_rst};
        end
    end

    assign locked_s = locked_sync_r[SYNC_STAGES-1];
    assign btn_s    = btn_sync_r[SYNC_STAGES-1];

`ifdef BTN_DEBOUNCE_EN
    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    logic        btn_req_r;
    logic [15:0] deb_cnt_r;

    // Debounce: btn_req follows btn_s only after it differs for DEBOUNCE_CYCLES consecutive edges
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            btn_req_r <= 1'b0;
            deb_cnt_r <= 16'd0;
        end else if (btn_s == btn_req_r) begin
            deb_cnt_r <= 16'd0;
        end else if (deb_cnt_r == DEB_LAST) begin
            btn_req_r <= btn_s;
            deb_cnt_r <= 16'd0;
        end else begin
            deb_cnt_r <= deb_cnt_r + 16'd1;
        end
    end

    assign btn_req = btn_req_r;
`else
    assign btn_req = btn_s;
`endif

    assign src_ok = locked_s & ~btn_req;

    // Sequencer state, counters and registered reset outputs
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_ASSERT;
            cnt_r      <= '0;
            stage_r    <= '0;
            rst_out_r  <= ALL_ONES;
            rst_done_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            stage_r    <= stage_n;
            rst_out_r  <= rst_out_n;
            rst_done_r <= rst_done_n;
        end
    end

    // Next-state logic; any loss of src_ok collapses straight back to full assertion
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        stage_n    = stage_r;
        rst_out_n  = rst_out_r;
        rst_done_n = rst_done_r;
        case (state_r)
            ST_ASSERT: begin
                rst_out_n  = ALL_ONES;
                rst_done_n = 1'b0;
                stage_n    = '0;
                if (!src_ok) begin
                    cnt_n = '0;
                end else if (cnt_r == HOLD_LAST) begin
                    cnt_n     = '0;
                    rst_out_n = ALL_ONES & ~ONE;
                    if (MULTI) begin
                        state_n = ST_RELEASE;
                        stage_n = IDX_W'(1'b1);
                    end else begin
                        state_n    = ST_RUN;
                        rst_done_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_RELEASE: begin
                if (!src_ok) begin
                    state_n    = ST_ASSERT;
                    cnt_n      = '0;
                    stage_n    = '0;
                    rst_out_n  = ALL_ONES;
                    rst_done_n = 1'b0;
                end else if (cnt_r == GAP_LAST) begin
                    cnt_n     = '0;
                    rst_out_n = rst_out_r & ~(ONE << stage_r);
                    if (stage_r == LAST_IDX) begin
                        state_n    = ST_RUN;
                        rst_done_n = 1'b1;
                    end else begin
                        stage_n = stage_r + IDX_W'(1'b1);
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_RUN: begin
                if (!src_ok) begin
                    state_n    = ST_ASSERT;
                    cnt_n      = '0;
                    stage_n    = '0;
                    rst_out_n  = ALL_ONES;
                    rst_done_n = 1'b0;
                end else begin
                    cnt_n = '0;
                end
            end
            default: begin
                state_n    = ST_ASSERT;
                cnt_n      = '0;
                stage_n    = '0;
                rst_out_n  = ALL_ONES;
                rst_done_n = 1'b0;
            end
        endcase
    end

    assign rst_out   = rst_out_r;
    assign rst_done  = rst_done_r;
    assign seq_state = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (default build): table of expected
// outputs per phase, queued into a scoreboard and compared at the listed edges.
module tb_reset_sequencer;

    logic       pclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       btn_rst;
    logic [2:0] rst_out;
    logic       rst_done;
    logic [1:0] seq_state;

    always #5 pclk = ~pclk;

    reset_sequencer dut (
        .pclk      (pclk),
        .rst       (rst),
        .locked    (locked),
        .btn_rst   (btn_rst),
        .rst_out   (rst_out),
        .rst_done  (rst_done),
        .seq_state (seq_state)
    );

    typedef struct {
        int         phase;
        int         edge_no;
        logic [2:0] ro;
        logic       done;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   edge_cnt     = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input int p, input int e, input logic [2:0] ro,
                                input logic done, input logic [1:0] st);
        vec_t v;
        v.phase = p; v.edge_no = e; v.ro = ro; v.done = done; v.st = st;
        vecs.push_back(v);
    endfunction

    task automatic load_phase(input int p);
        edge_cnt = 0;
        for (int i = 0; i < vecs.size(); i++)
            if (vecs[i].phase == p) sb.push_back(vecs[i]);
    endtask

    // Advance n edges; sample #1 after each rising edge and retire due expectations
    task automatic run_edges(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            edge_cnt++;
            while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                v = sb.pop_front();
                check($sformatf("p%0d e%0d rst_out", v.phase, v.edge_no), 8'(rst_out), 8'(v.ro));
                check($sformatf("p%0d e%0d rst_done", v.phase, v.edge_no), 8'(rst_done), 8'(v.done));
                check($sformatf("p%0d e%0d seq_state", v.phase, v.edge_no), 8'(seq_state), 8'(v.st));
            end
        end
    endtask

    task automatic finish_phase(input int p);
        check($sformatf("p%0d pending", p), 8'(sb.size()), 8'd0);
        sb.delete();
    endtask

    initial begin
        // Phase 1: power-up release timing
        add(1, 17, 3'b111, 1'b0, 2'd0); add(1, 18, 3'b110, 1'b0, 2'd1);
        add(1, 25, 3'b110, 1'b0, 2'd1); add(1, 26, 3'b100, 1'b0, 2'd1);
        add(1, 33, 3'b100, 1'b0, 2'd1); add(1, 34, 3'b000, 1'b1, 2'd2);
        add(1, 40, 3'b000, 1'b1, 2'd2);
        // Phase 2: lock loss in RUN, recovery 18 edges after lock returns
        add(2, 3, 3'b111, 1'b0, 2'd0); add(2, 22, 3'b111, 1'b0, 2'd0);
        add(2, 23, 3'b110, 1'b0, 2'd1); add(2, 25, 3'b110, 1'b0, 2'd1);
        // Phase 3: button during RELEASE
        add(3, 3, 3'b111, 1'b0, 2'd0); add(3, 21, 3'b111, 1'b0, 2'd0);
        add(3, 22, 3'b110, 1'b0, 2'd1); add(3, 30, 3'b100, 1'b0, 2'd1);
        add(3, 38, 3'b000, 1'b1, 2'd2);
        // Phase 4: one-cycle lock glitch at cnt = 10 restarts the hold
        add(4, 12, 3'b111, 1'b0, 2'd0); add(4, 18, 3'b111, 1'b0, 2'd0);
        add(4, 30, 3'b111, 1'b0, 2'd0); add(4, 31, 3'b110, 1'b0, 2'd1);
        add(4, 39, 3'b100, 1'b0, 2'd1); add(4, 47, 3'b000, 1'b1, 2'd2);
        // Phase 6: src_ok drops on the edge the hold would complete
        add(6, 17, 3'b111, 1'b0, 2'd0); add(6, 18, 3'b111, 1'b0, 2'd0);
        add(6, 33, 3'b111, 1'b0, 2'd0); add(6, 34, 3'b110, 1'b0, 2'd1);

        locked  = 1'b1;
        btn_rst = 1'b0;
        rst     = 1'b1;
        #1;
        check("reset rst_out", 8'(rst_out), 8'h07);
        check("reset rst_done", 8'(rst_done), 8'h00);
        check("reset seq_state", 8'(seq_state), 8'h00);
        repeat (3) @(posedge pclk);
        #1;
        rst = 1'b0;
        load_phase(1);
        run_edges(40);
        finish_phase(1);

        load_phase(2);
        locked = 1'b0;
        run_edges(5);
        locked = 1'b1;
        run_edges(20);
        finish_phase(2);

        load_phase(3);
        btn_rst = 1'b1;
        run_edges(4);
        btn_rst = 1'b0;
        run_edges(40);
        finish_phase(3);

        rst = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        load_phase(4);
        run_edges(12);
        locked = 1'b0;
        run_edges(1);
        locked = 1'b1;
        run_edges(35);
        finish_phase(4);

        // Phase 5: asynchronous rst between edges while in RUN
        check("p5 pre rst_done", 8'(rst_done), 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("p5 async rst_out", 8'(rst_out), 8'h07);
        check("p5 async rst_done", 8'(rst_done), 8'h00);
        check("p5 async seq_state", 8'(seq_state), 8'h00);
        @(posedge pclk);
        #1;
        rst = 1'b0;

        load_phase(6);
        run_edges(15);
        locked = 1'b0;
        run_edges(1);
        locked = 1'b1;
        run_edges(20);
        finish_phase(6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
